// File: rtl/sap_controller.sv
// SAP-1 control sequencer: one-hot T-state ring counter on the falling clock edge plus a
// combinational control word. Define SAP_EARLY_FETCH_EN to end short instructions early.
module sap_controller (
    input  logic        CLK,
    input  logic        CLR_N,
    input  logic [3:0]  OPCODE,
    output logic [11:0] CON,
    output logic [5:0]  T,
    output logic        HALT
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word layout: {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
    localparam logic [11:0] CON_IDLE    = 12'h3E3;
    localparam logic [11:0] CON_FETCH1  = 12'h5E3;
    localparam logic [11:0] CON_FETCH2  = 12'hBE3;
    localparam logic [11:0] CON_FETCH3  = 12'h263;
    localparam logic [11:0] CON_ADDR    = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5  = 12'h2C3;
    localparam logic [11:0] CON_LDB     = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6  = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6  = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4  = 12'h3F2;

`ifdef SAP_EARLY_FETCH_EN
    localparam logic EARLY_FETCH = 1'b1;
`else
    localparam logic EARLY_FETCH = 1'b0;
`endif

    tstate_e t_q, t_d;
    logic    halt_q, halt_d;
    logic    is_nop, end_at_t4, end_at_t5;

    assign is_nop    = !(OPCODE inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
    assign end_at_t4 = EARLY_FETCH && ((OPCODE == OP_OUT) || is_nop);
    assign end_at_t5 = EARLY_FETCH && (OPCODE == OP_LDA);

    always_ff @(negedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            t_q    <= T1;
            halt_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            halt_q <= halt_d;
        end
    end

    always_comb begin
        t_d    = t_q;
        halt_d = halt_q;
        if (!halt_q) begin
            case (t_q)
                T1: t_d = T2;
                T2: t_d = T3;
                T3: t_d = T4;
                T4: begin
                    if (OPCODE == OP_HLT) begin
                        halt_d = 1'b1;
                        t_d    = T4;
                    end else if (end_at_t4) begin
                        t_d = T1;
                    end else begin
                        t_d = T5;
                    end
                end
                T5: t_d = end_at_t5 ? T1 : T6;
                T6: t_d = T1;
                // Any corrupted encoding recovers to a legal one-hot state
                default: t_d = T1;
            endcase
        end
    end

    // Reset and halt both gate the word so no strobe survives an abort
    always_comb begin
        CON = CON_IDLE;
        if (CLR_N && !halt_q) begin
            case (t_q)
                T1: CON = CON_FETCH1;
                T2: CON = CON_FETCH2;
                T3: CON = CON_FETCH3;
                T4: begin
                    case (OPCODE)
                        OP_LDA, OP_ADD, OP_SUB: CON = CON_ADDR;
                        OP_OUT:                 CON = CON_OUT_T4;
                        default:                CON = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (OPCODE)
                        OP_LDA:         CON = CON_LDA_T5;
                        OP_ADD, OP_SUB: CON = CON_LDB;
                        default:        CON = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (OPCODE)
                        OP_ADD:  CON = CON_ADD_T6;
                        OP_SUB:  CON = CON_SUB_T6;
                        default: CON = CON_IDLE;
                    endcase
                end
                default: CON = CON_IDLE;
            endcase
        end
    end

    assign T    = t_q;
    assign HALT = halt_q;

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: stimulus pushes the reference model's expected
// T/CON/HALT each cycle; a monitor pops and compares on the rising edge.
module tb_sap_controller;
    logic        CLK;
    logic        CLR_N;
    logic [3:0]  OPCODE;
    logic [11:0] CON;
    logic [5:0]  T;
    logic        HALT;

    sap_controller dut (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .OPCODE (OPCODE),
        .CON    (CON),
        .T      (T),
        .HALT   (HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  t;
        logic [11:0] con;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Reference model: step number 1..6, halt flag, and the inputs applied this cycle
    int       m_step = 1;
    bit       m_halt = 1'b0;
    bit       m_rst  = 1'b0;
    bit [3:0] m_op   = 4'h0;

    function automatic int last_step(input bit [3:0] op);
`ifdef SAP_EARLY_FETCH_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2 || op == 4'hF) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    function automatic logic [11:0] model_con(input int step, input bit [3:0] op,
                                              input bit halted, input bit rst_n);
        logic [11:0] fetch [3];
        logic [11:0] exec  [3];
        fetch = '{12'h5E3, 12'hBE3, 12'h263};
        if (!rst_n || halted) return 12'h3E3;
        if (step <= 3) return fetch[step-1];
        case (op)
            4'h0:    exec = '{12'h1A3, 12'h2C3, 12'h3E3};
            4'h1:    exec = '{12'h1A3, 12'h2E1, 12'h3C7};
            4'h2:    exec = '{12'h1A3, 12'h2E1, 12'h3CF};
            4'hE:    exec = '{12'h3F2, 12'h3E3, 12'h3E3};
            default: exec = '{12'h3E3, 12'h3E3, 12'h3E3};
        endcase
        return exec[step-4];
    endfunction

    task automatic model_edge();
        if (!m_rst) begin
            m_step = 1;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 4 && m_op == 4'hF) m_halt = 1'b1;
            else if (m_step >= last_step(m_op)) m_step = 1;
            else m_step = m_step + 1;
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.t    = 6'(1 << (m_step - 1));
        e.con  = model_con(m_step, m_op, m_halt, m_rst);
        e.halt = m_halt;
        exp_q.push_back(e);
    endtask

    // One machine clock: state moves on the falling edge, then new inputs are applied
    task automatic step_cycle(input logic [3:0] op, input logic rst_n_val);
        @(negedge CLK);
        model_edge();
        #1;
        OPCODE = op;
        CLR_N  = rst_n_val;
        m_op   = op;
        m_rst  = rst_n_val;
        if (!rst_n_val) begin
            m_step = 1;
            m_halt = 1'b0;
        end
        push_expected();
    endtask

    task automatic run(input logic [3:0] op, input int n);
        for (int i = 0; i < n; i++) step_cycle(op, 1'b1);
    endtask

    // Assert reset between clock edges and check its immediate effect
    task automatic pulse_reset_mid();
        @(posedge CLK);
        #2;
        CLR_N  = 1'b0;
        m_rst  = 1'b0;
        m_step = 1;
        m_halt = 1'b0;
        #1;
        check("async_rst_con", CON, 12'h3E3);
        check("async_rst_t", {6'd0, T}, 12'h001);
        check("async_rst_halt", {11'd0, HALT}, 12'h000);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: T=%b CON=%h HALT=%b", txn, T, CON, HALT);
                check("sb_t", {6'd0, T}, {6'd0, e.t});
                check("sb_con", CON, e.con);
                check("sb_halt", {11'd0, HALT}, {11'd0, e.halt});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int halt_cnt;
        bit rst_v;
        CLR_N  = 1'b1;
        OPCODE = 4'h0;
        #2;
        CLR_N  = 1'b0;
        #1;
        check("init_rst_con", CON, 12'h3E3);
        check("init_rst_t", {6'd0, T}, 12'h001);
        check("init_rst_halt", {11'd0, HALT}, 12'h000);

        for (int i = 0; i < 3; i++) step_cycle(4'h0, 1'b0);

        // Release, then full ADD, SUB and OUT instructions
        run(4'h1, 1);
        run(4'h1, 6);
        run(4'h2, 6);
        run(4'hE, 6);

        // LDA aborted by reset while in T5
        pulse_reset_mid();
        run(4'h0, 1);
        run(4'h0, 4);
        pulse_reset_mid();

        // HLT: freeze for 20+ cycles, then reset while halted
        run(4'hF, 1);
        run(4'hF, 3);
        run(4'hF, 21);
        pulse_reset_mid();
        run(4'h0, 1);

        // Random opcodes every cycle, occasional resets, forced reset after a halt
        halt_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            rst_v = ($urandom_range(0, 39) != 0);
            if (m_halt) begin
                halt_cnt++;
                if (halt_cnt > 4) begin
                    rst_v    = 1'b0;
                    halt_cnt = 0;
                end
            end else begin
                halt_cnt = 0;
            end
            step_cycle(4'($urandom_range(0, 15)), rst_v);
        end

        @(posedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 SHALL have port: CLK  input  1  system clock; ring counter advances on falling edge, datapath registers load on rising edge.
REQ-002 SHALL have port: CLR_N  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: OPCODE  input  4  instruction register upper nibble.
REQ-004 SHALL have port: CON  output  12  control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}, bit 11 = Cp.
REQ-005 SHALL have port: T  output  6  one-hot T-state, bit0 = T1 ... bit5 = T6.
REQ-006 SHALL have port: HALT  output  1  registered halt flag.
REQ-007 SHALL have one clock (CLK); reset SHALL be asynchronous and active-low (CLR_N).

Function
REQ-008 SHALL hold T as a one-hot ring counter updated only on falling edge of CLK.
REQ-009 SHALL derive CON combinationally from T, OPCODE and HALT, with no extra latency.
REQ-010 SHALL define idle word 0x3E3: all strobes deasserted.
REQ-011 SHALL drive fetch words independent of OPCODE: T1=0x5E3 (Ep, Lm_n), T2=0xBE3 (Cp), T3=0x263 (CE_n, Li_n).
REQ-012 SHALL decode LDA=0000 as: T4=0x1A3 (Ei_n, Lm_n), T5=0x2C3 (CE_n, La_n), T6=0x3E3.
REQ-013 SHALL decode ADD=0001 as: T4=0x1A3, T5=0x2E1 (CE_n, Lb_n), T6=0x3C7 (La_n, Eu).
REQ-014 SHALL decode SUB=0010 as ADD, except T6=0x3CF (La_n, Eu, Su); Su SHALL be asserted in T6 only.
REQ-015 SHALL decode OUT=1110 as: T4=0x3F2 (Ea, Lo_n), T5 and T6=0x3E3.
REQ-016 SHALL treat all other opcodes except 1111 as NOP: T4..T6=0x3E3.
REQ-017 SHALL handle HLT=1111 as: on the falling edge leaving T4, set HALT=1 and hold T at T4 instead of advancing.
REQ-018 SHALL, while HALT=1, keep T frozen, force CON=0x3E3, and clear HALT only via CLR_N.
REQ-019 SHALL wrap from T6 to T1 on the next falling edge.
REQ-020 SHALL sample OPCODE only during T4..T6; OPCODE changes during T1..T3 SHALL have no effect on CON.
REQ-021 SHALL never drive T to a value other than exactly one bit set, including after reset release.

Reset
REQ-022 SHALL, while CLR_N=0, immediately force T=6'b000001, HALT=0 and CON=0x3E3, regardless of CLK.
REQ-023 SHALL, on CLR_N assertion mid-instruction (any T-state, halted or not), abort the instruction with no further strobes.
REQ-024 SHALL, after CLR_N deasserts, output the T1 word 0x5E3 and advance to T2 on the first falling edge of CLK.

Configuration
REQ-025 SHALL support macro SAP_EARLY_FETCH_EN to select the machine cycle length.
REQ-026 SHALL, when SAP_EARLY_FETCH_EN is defined, return to T1 after the last active state: LDA after T5; OUT and NOP after T4; ADD/SUB after T6; HLT unchanged.
REQ-027 SHALL, when SAP_EARLY_FETCH_EN is not defined, use a fixed six-state cycle for every opcode.

Verification
REQ-028 SHALL verify reset: CLR_N=0 with CLK running -> T=000001, HALT=0, CON=0x3E3; then release CLR_N -> CON=0x5E3, and one falling edge later T=000010, CON=0xBE3.
REQ-029 SHALL verify ADD: OPCODE=0001 across six falling edges -> CON sequence 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2E1, 0x3C7, then back to 0x5E3.
REQ-030 SHALL verify SUB and OUT: OPCODE=0010 -> T6 CON=0x3CF; OPCODE=1110 -> T4 CON=0x3F2 and T5=T6=0x3E3.
REQ-031 SHALL verify HLT: OPCODE=1111 at T4 -> after the next falling edge HALT=1, T=001000, CON=0x3E3, stable for 20 cycles; then CLR_N pulse -> HALT=0, T=000001.
REQ-032 SHALL verify reset mid-operation: LDA in T5 (CON=0x2C3), CLR_N pulsed low between clock edges -> CON=0x3E3 immediately and T=000001.
REQ-033 SHALL verify SAP_EARLY_FETCH_EN defined: LDA -> T5 followed by T1 (5 states); OUT -> T4 followed by T1; ADD still 6 states.
